re_control_multi: RTL and testbench



---
 rtl/re_control_multi_pkg.sv | 44 ++++
 rtl/re_control_multi_exp.sv | 27 ++
 rtl/re_control_multi.sv | 162 ++++++++++++++++
 tb/tb_re_control_multi.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/re_control_multi_pkg.sv
// Shared types and helpers for the row readout/exposure controller.
// RE_CDS_EN selects the 5-step correlated-double-sampling row sequence.
package re_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPOSURE,
    READOUT
  } state_t;

  typedef enum logic [1:0] {
    SEL,
    SEL_ADC,
    GAP
  } phase_t;

`ifdef RE_CDS_EN
  localparam int ROW_STEPS = 5;
`else
  localparam int ROW_STEPS = 4;
`endif

  function automatic int readout_len(input int num_rows);
    return 2 + ROW_STEPS * num_rows;
  endfunction

  function automatic phase_t row_phase(input int p);
    phase_t ph;
    ph = SEL;
`ifdef RE_CDS_EN
    if (p == 4)
      ph = GAP;
    else if (p == 1 || p == 3)
      ph = SEL_ADC;
`else
    if (p == 3)
      ph = GAP;
    else if (p == 1)
      ph = SEL_ADC;
`endif
    return ph;
  endfunction

endpackage

// File: rtl/re_control_multi_exp.sv
// Saturating up/down exposure-time register.
// Both or neither control asserted holds the value.
module re_exp_time_reg #(
  parameter int EXP_W       = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increase,
  input  logic             decrease,
  output logic [EXP_W-1:0] t_exp
);

  always_ff @(posedge clk) begin
    if (!reset)
      t_exp <= EXP_W'(EXP_DEFAULT);
    else if (increase && !decrease &&
             t_exp < EXP_W'(EXP_MAX))
      t_exp <= t_exp + 1'b1;
    else if (decrease && !increase &&
             t_exp > EXP_W'(EXP_MIN))
      t_exp <= t_exp - 1'b1;
  end

endmodule

// File: rtl/re_control_multi.sv
// Multi-row erase/exposure/readout sequencer, all outputs registered.
// Optional RE_CDS_EN adds a second ADC sample per row and adc_sig.
module re_control_multi
  import re_ctrl_pkg::*;
#(
  parameter int NUM_ROWS    = 2,
  parameter int EXP_W       = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                continuous,
  input  logic                abort,
  input  logic                increase,
  input  logic                decrease,
  output logic [NUM_ROWS-1:0] nre,
  output logic                adc,
  output logic                expose,
  output logic                erase,
  output logic                busy,
  output logic                frame_done,
`ifdef RE_CDS_EN
  output logic                adc_sig,
`endif
  output logic [EXP_W-1:0]    t_exp
);

  localparam int L  = readout_len(NUM_ROWS);
  localparam int SW = $clog2(L + 1);

  state_t              state, state_n;
  logic [EXP_W-1:0]    exp_cnt, exp_cnt_n;
  logic [EXP_W-1:0]    t_shadow, t_shadow_n;
  logic [SW-1:0]       step, step_n;
  logic [NUM_ROWS-1:0] nre_n;
  logic                adc_n;
  logic                done_n;
  phase_t              ph;
`ifdef RE_CDS_EN
  logic                adc_sig_n;
`endif

  re_exp_time_reg #(
    .EXP_W      (EXP_W),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX),
    .EXP_DEFAULT(EXP_DEFAULT)
  ) u_exp (
    .clk     (clk),
    .reset   (reset),
    .increase(increase),
    .decrease(decrease),
    .t_exp   (t_exp)
  );

  always_comb begin
    state_n    = state;
    exp_cnt_n  = exp_cnt;
    step_n     = step;
    t_shadow_n = t_shadow;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if ((init || continuous) && !abort) begin
          state_n    = EXPOSURE;
          exp_cnt_n  = '0;
          t_shadow_n = t_exp;
        end
      end
      EXPOSURE: begin
        if (abort) begin
          state_n   = IDLE;
          exp_cnt_n = '0;
        end else if (exp_cnt == t_shadow - 1'b1) begin
          state_n   = READOUT;
          exp_cnt_n = '0;
          step_n    = '0;
        end else begin
          exp_cnt_n = exp_cnt + 1'b1;
        end
      end
      READOUT: begin
        if (abort) begin
          state_n = IDLE;
          step_n  = '0;
        end else if (step == SW'(L - 1)) begin
          state_n = IDLE;
          step_n  = '0;
          done_n  = 1'b1;
        end else begin
          step_n = step + 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        exp_cnt_n = '0;
        step_n    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    nre_n = '1;
    adc_n = 1'b0;
    ph    = GAP;
`ifdef RE_CDS_EN
    adc_sig_n = 1'b0;
`endif
    if (state_n == READOUT) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int p = 0; p < ROW_STEPS; p++) begin
          if (int'(step_n) == 2 + ROW_STEPS * r + p) begin
            ph = row_phase(p);
            if (ph != GAP)
              nre_n[r] = 1'b0;
            adc_n = (ph == SEL_ADC);
`ifdef RE_CDS_EN
            adc_sig_n = (p == 3);
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      exp_cnt    <= '0;
      step       <= '0;
      t_shadow   <= '0;
      nre        <= '1;
      adc        <= 1'b0;
      expose     <= 1'b0;
      erase      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef RE_CDS_EN
      adc_sig    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      exp_cnt    <= exp_cnt_n;
      step       <= step_n;
      t_shadow   <= t_shadow_n;
      nre        <= nre_n;
      adc        <= adc_n;
      expose     <= (state_n == EXPOSURE);
      erase      <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      frame_done <= done_n;
`ifdef RE_CDS_EN
      adc_sig    <= adc_sig_n;
`endif
    end
  end

endmodule

// File: tb/tb_re_control_multi.sv
// Directed bench for re_control_multi at default parameters.
// Inputs change and outputs are sampled on the falling edge.
module tb_re_control_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       continuous;
  logic       abort;
  logic       increase;
  logic       decrease;
  logic [1:0] nre;
  logic       adc;
  logic       expose;
  logic       erase;
  logic       busy;
  logic       frame_done;
  logic [4:0] t_exp;
`ifdef RE_CDS_EN
  logic       adc_sig;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [1:0] nre_tbl [10] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b01, 2'b01, 2'b01, 2'b11};

  re_control_multi dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .continuous(continuous),
    .abort     (abort),
    .increase  (increase),
    .decrease  (decrease),
    .nre       (nre),
    .adc       (adc),
    .expose    (expose),
    .erase     (erase),
    .busy      (busy),
    .frame_done(frame_done),
`ifdef RE_CDS_EN
    .adc_sig   (adc_sig),
`endif
    .t_exp     (t_exp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic start;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Called at the first exposure cycle; optionally pulses increase.
  task automatic run_frame(input int te, input logic [31:0] inc_mask);
    for (int i = 0; i < te; i++) begin
      chk("expose", expose, 1);
      chk("busy_exp", busy, 1);
      chk("nre_exp", nre, 2'b11);
      increase = inc_mask[i];
      @(negedge clk);
    end
    increase = 1'b0;
    for (int s = 0; s < 10; s++) begin
      chk("expose_ro", expose, 0);
      chk("nre_ro", nre, nre_tbl[s]);
      chk("adc_ro", adc, (s == 3 || s == 7));
      chk("done_ro", frame_done, 0);
      @(negedge clk);
    end
    chk("frame_done", frame_done, 1);
    chk("erase_done", erase, 1);
    @(negedge clk);
    chk("done_once", frame_done, 0);
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      if (frame_done) begin
        c = cyc;
        return;
      end
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    int c1, c2, c3;
    reset = 1'b0; init = 1'b0; continuous = 1'b0;
    abort = 1'b0; increase = 1'b0; decrease = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_erase", erase, 1);
    chk("rst_nre", nre, 2'b11);
    chk("rst_adc", adc, 0);
    chk("rst_expose", expose, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_texp", t_exp, 5);
    reset = 1'b1;
    @(negedge clk);

    start();
    run_frame(5, 0);

    increase = 1'b1;
    repeat (40) @(negedge clk);
    increase = 1'b0;
    chk("texp_max", t_exp, 30);
    decrease = 1'b1;
    repeat (40) @(negedge clk);
    decrease = 1'b0;
    chk("texp_min", t_exp, 2);
    increase = 1'b1; decrease = 1'b1;
    repeat (5) @(negedge clk);
    increase = 1'b0; decrease = 1'b0;
    chk("texp_both", t_exp, 2);
    chk("idle_erase", erase, 1);
    increase = 1'b1;
    @(negedge clk);
    increase = 1'b0;
    chk("texp_3", t_exp, 3);

    continuous = 1'b1;
    wait_done(c1);
    @(negedge clk);
    wait_done(c2);
    @(negedge clk);
    wait_done(c3);
    continuous = 1'b0;
    chk("cont_erase", erase, 1);
    chk("period1", c2 - c1, 14);
    chk("period2", c3 - c2, 14);
    @(negedge clk);
    chk("cont_stop", expose, 0);

    increase = 1'b1;
    repeat (2) @(negedge clk);
    increase = 1'b0;
    chk("texp_5", t_exp, 5);

    init = 1'b1; abort = 1'b1;
    @(negedge clk);
    init = 1'b0; abort = 1'b0;
    chk("abort_blk_exp", expose, 0);
    chk("abort_blk_busy", busy, 0);

    start();
    repeat (5) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("step4_nre", nre, 2'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_erase", erase, 1);
    chk("abort_nre", nre, 2'b11);
    chk("abort_adc", adc, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nodone", frame_done, 0);
    start();
    run_frame(5, 0);

    start();
    run_frame(5, 32'b0110);
    chk("texp_7", t_exp, 7);
    start();
    run_frame(7, 0);

    init = 1'b1; reset = 1'b0; increase = 1'b1;
    @(negedge clk);
    init = 1'b0; reset = 1'b1; increase = 1'b0;
    chk("rst2_texp", t_exp, 5);
    chk("rst2_erase", erase, 1);
    chk("rst2_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
